// File: rtl/data_mem_interface.sv
// data_mem_interface
//
// Multi-cycle access controller between the core's memory stage and a
// word-organised data memory. It latches a load/store request, runs a
// strobe/acknowledge handshake and, for byte stores, performs a
// read-modify-write on the word-only memory.
//
// Configuration macro: DATA_MEM_BYTE_ENABLE_EN
//   undefined : byte stores are read-modify-write, Mem_BE = 4'b1111 on writes
//   defined   : byte stores are a single write with one-hot Mem_BE and the
//               store byte replicated to all four lanes
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   Mem_Req           start access (sampled only in IDLE)
//   Mem_Write         1 = store, 0 = load
//   Store_Select      1 = byte store, 0 = word store
//   Address           byte address
//   Store_Data        store data, byte stores use [7:0]
//   Busy              high from the cycle after acceptance through DONE
//   Done              one-cycle completion pulse
//   Load_Memory       word read by the last load
//   Offset            Address[1:0] of the last accepted access
//   Mem_Addr          word address to memory
//   Mem_Rd, Mem_Wr    read / write strobes
//   Mem_WData, Mem_BE write data and byte enables
//   Mem_Ack           memory acknowledge
//   Mem_RData         memory read data
module data_mem_interface (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_Req,
  input  logic        Mem_Write,
  input  logic        Store_Select,
  input  logic [31:0] Address,
  input  logic [31:0] Store_Data,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Load_Memory,
  output logic [1:0]  Offset,
  output logic [29:0] Mem_Addr,
  output logic        Mem_Rd,
  output logic        Mem_Wr,
  output logic [31:0] Mem_WData,
  output logic [3:0]  Mem_BE,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_RData
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRmwRd,
    StRmwWr,
    StWr,
    StDone
  } state_e;

  state_e      state_q;
  logic [7:0]  store_byte_q;
  logic [31:0] merged_word;

  // Read word with the addressed byte lane replaced by the latched store byte.
  always_comb begin
    merged_word = Mem_RData;
    unique case (Offset)
      2'd0: merged_word[7:0]   = store_byte_q;
      2'd1: merged_word[15:8]  = store_byte_q;
      2'd2: merged_word[23:16] = store_byte_q;
      2'd3: merged_word[31:24] = store_byte_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      store_byte_q <= 8'h00;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Load_Memory  <= 32'h0;
      Offset       <= 2'b00;
      Mem_Addr     <= 30'h0;
      Mem_Rd       <= 1'b0;
      Mem_Wr       <= 1'b0;
      Mem_WData    <= 32'h0;
      Mem_BE       <= 4'b0000;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Mem_Req) begin
            Busy     <= 1'b1;
            Mem_Addr <= Address[31:2];
            Offset   <= Address[1:0];
            if (!Mem_Write) begin
              state_q <= StRd;
              Mem_Rd  <= 1'b1;
            end else if (!Store_Select) begin
              state_q   <= StWr;
              Mem_Wr    <= 1'b1;
              Mem_WData <= Store_Data;
              Mem_BE    <= 4'b1111;
            end else begin
`ifdef DATA_MEM_BYTE_ENABLE_EN
              state_q   <= StWr;
              Mem_Wr    <= 1'b1;
              Mem_WData <= {4{Store_Data[7:0]}};
              Mem_BE    <= 4'b0001 << Address[1:0];
`else
              state_q      <= StRmwRd;
              Mem_Rd       <= 1'b1;
              store_byte_q <= Store_Data[7:0];
`endif
            end
          end
        end
        StRd: begin
          if (Mem_Ack) begin
            Load_Memory <= Mem_RData;
            Mem_Rd      <= 1'b0;
            Done        <= 1'b1;
            state_q     <= StDone;
          end
        end
        StRmwRd: begin
          // The merged word goes to the write buffer only; Load_Memory is untouched.
          if (Mem_Ack) begin
            Mem_Rd    <= 1'b0;
            Mem_Wr    <= 1'b1;
            Mem_WData <= merged_word;
            Mem_BE    <= 4'b1111;
            state_q   <= StRmwWr;
          end
        end
        StRmwWr, StWr: begin
          if (Mem_Ack) begin
            Mem_Wr  <= 1'b0;
            Mem_BE  <= 4'b0000;
            Done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          // Requests seen here are dropped; the next one is taken in IDLE.
          Busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_interface.sv
module tb_data_mem_interface;

  logic        clk;
  logic        rst_n;
  logic        Mem_Req;
  logic        Mem_Write;
  logic        Store_Select;
  logic [31:0] Address;
  logic [31:0] Store_Data;
  logic        Busy;
  logic        Done;
  logic [31:0] Load_Memory;
  logic [1:0]  Offset;
  logic [29:0] Mem_Addr;
  logic        Mem_Rd;
  logic        Mem_Wr;
  logic [31:0] Mem_WData;
  logic [3:0]  Mem_BE;
  logic        Mem_Ack;
  logic [31:0] Mem_RData;

  int ntests = 0;
  int nfail  = 0;

  data_mem_interface dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Mem_Req      (Mem_Req),
    .Mem_Write    (Mem_Write),
    .Store_Select (Store_Select),
    .Address      (Address),
    .Store_Data   (Store_Data),
    .Busy         (Busy),
    .Done         (Done),
    .Load_Memory  (Load_Memory),
    .Offset       (Offset),
    .Mem_Addr     (Mem_Addr),
    .Mem_Rd       (Mem_Rd),
    .Mem_Wr       (Mem_Wr),
    .Mem_WData    (Mem_WData),
    .Mem_BE       (Mem_BE),
    .Mem_Ack      (Mem_Ack),
    .Mem_RData    (Mem_RData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic bsel, input logic [31:0] addr,
                     input logic [31:0] sdata);
    Mem_Req      = 1'b1;
    Mem_Write    = wr;
    Store_Select = bsel;
    Address      = addr;
    Store_Data   = sdata;
  endtask

  initial begin
    rst_n = 1'b0; Mem_Req = 1'b0; Mem_Write = 1'b0; Store_Select = 1'b0;
    Address = 32'h0; Store_Data = 32'h0; Mem_Ack = 1'b0; Mem_RData = 32'h0;
    tick(); tick();

    // Reset state
    chk("rst_busy",  32'(Busy),        32'h0);
    chk("rst_done",  32'(Done),        32'h0);
    chk("rst_rd",    32'(Mem_Rd),      32'h0);
    chk("rst_wr",    32'(Mem_Wr),      32'h0);
    chk("rst_load",  Load_Memory,      32'h0);
    chk("rst_off",   32'(Offset),      32'h0);
    chk("rst_addr",  32'(Mem_Addr),    32'h0);
    chk("rst_wdata", Mem_WData,        32'h0);
    chk("rst_be",    32'(Mem_BE),      32'h0);
    rst_n = 1'b1;
    tick();

    // Load, zero wait
    req(1'b0, 1'b0, 32'h0000_0104, 32'h0);
    Mem_Ack = 1'b1; Mem_RData = 32'hA1B2_C3D4;
    tick(); Mem_Req = 1'b0;
    chk("ld0_rd",    32'(Mem_Rd),   32'h1);
    chk("ld0_wr",    32'(Mem_Wr),   32'h0);
    chk("ld0_addr",  32'(Mem_Addr), 32'h41);
    chk("ld0_busy",  32'(Busy),     32'h1);
    chk("ld0_ndone", 32'(Done),     32'h0);
    tick();
    chk("ld0_done",  32'(Done),     32'h1);
    chk("ld0_data",  Load_Memory,   32'hA1B2_C3D4);
    chk("ld0_off",   32'(Offset),   32'h0);
    chk("ld0_rdoff", 32'(Mem_Rd),   32'h0);
    Mem_Ack = 1'b0;
    tick();
    chk("ld0_pulse", 32'(Done),     32'h0);
    chk("ld0_idle",  32'(Busy),     32'h0);

    // Load, 3 wait cycles
    req(1'b0, 1'b0, 32'h0000_0013, 32'h0);
    Mem_RData = 32'hDEAD_BEEF;
    tick(); Mem_Req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ld3_rd",   32'(Mem_Rd),   32'h1);
      chk("ld3_addr", 32'(Mem_Addr), 32'h4);
      chk("ld3_wait", 32'(Done),     32'h0);
      tick();
    end
    Mem_Ack = 1'b1;
    chk("ld3_rd4",   32'(Mem_Rd),   32'h1);
    chk("ld3_addr4", 32'(Mem_Addr), 32'h4);
    tick(); Mem_Ack = 1'b0;
    chk("ld3_done",  32'(Done),     32'h1);
    chk("ld3_off",   32'(Offset),   32'h3);
    chk("ld3_data",  Load_Memory,   32'hDEAD_BEEF);
    tick();

    // Word store, issued in the first IDLE cycle after Done
    req(1'b1, 1'b0, 32'h0000_0208, 32'hCAFE_F00D);
    Mem_Ack = 1'b1;
    tick(); Mem_Req = 1'b0;
    chk("ws_wr",    32'(Mem_Wr),   32'h1);
    chk("ws_rd",    32'(Mem_Rd),   32'h0);
    chk("ws_addr",  32'(Mem_Addr), 32'h82);
    chk("ws_wdata", Mem_WData,     32'hCAFE_F00D);
    chk("ws_be",    32'(Mem_BE),   32'hF);
    tick(); Mem_Ack = 1'b0;
    chk("ws_done",  32'(Done),     32'h1);
    chk("ws_wroff", 32'(Mem_Wr),   32'h0);
    chk("ws_beoff", 32'(Mem_BE),   32'h0);
    chk("ws_load",  Load_Memory,   32'hDEAD_BEEF);
    tick();

    // Byte store at offset 1 over memory word 0x11223344
    req(1'b1, 1'b1, 32'h0000_0301, 32'h0000_00EE);
    Mem_Ack = 1'b1; Mem_RData = 32'h1122_3344;
    tick(); Mem_Req = 1'b0;
`ifdef DATA_MEM_BYTE_ENABLE_EN
    chk("bs_wr",    32'(Mem_Wr),   32'h1);
    chk("bs_rd",    32'(Mem_Rd),   32'h0);
    chk("bs_wdata", Mem_WData,     32'hEEEE_EEEE);
    chk("bs_be",    32'(Mem_BE),   32'h2);
    chk("bs_addr",  32'(Mem_Addr), 32'hC0);
`else
    chk("bs_rd",    32'(Mem_Rd),   32'h1);
    chk("bs_wr0",   32'(Mem_Wr),   32'h0);
    chk("bs_be0",   32'(Mem_BE),   32'h0);
    chk("bs_addr",  32'(Mem_Addr), 32'hC0);
    tick();
    chk("bs_wr",    32'(Mem_Wr),   32'h1);
    chk("bs_rd1",   32'(Mem_Rd),   32'h0);
    chk("bs_wdata", Mem_WData,     32'h1122_EE44);
    chk("bs_be",    32'(Mem_BE),   32'hF);
    chk("bs_ndone", 32'(Done),     32'h0);
`endif
    tick(); Mem_Ack = 1'b0;
    chk("bs_done",  32'(Done),     32'h1);
    chk("bs_off",   32'(Offset),   32'h1);
    chk("bs_load",  Load_Memory,   32'hDEAD_BEEF);
    tick();

    // Mem_Req held while busy and during DONE is ignored
    req(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    Mem_RData = 32'h55AA_55AA;
    tick();
    req(1'b1, 1'b0, 32'h0000_0080, 32'h1234_5678);
    for (int i = 0; i < 2; i++) begin
      chk("ign_addr", 32'(Mem_Addr), 32'h10);
      chk("ign_rd",   32'(Mem_Rd),   32'h1);
      chk("ign_wr",   32'(Mem_Wr),   32'h0);
      tick();
    end
    Mem_Ack = 1'b1;
    tick(); Mem_Ack = 1'b0;
    chk("ign_done",  32'(Done),    32'h1);
    chk("ign_data",  Load_Memory,  32'h55AA_55AA);
    tick(); Mem_Req = 1'b0;
    chk("ign_ndone", 32'(Done),    32'h0);
    chk("ign_idle",  32'(Busy),    32'h0);
    chk("ign_nwr",   32'(Mem_Wr),  32'h0);
    tick();
    chk("ign_nbusy", 32'(Busy),    32'h0);
    chk("ign_nrd",   32'(Mem_Rd),  32'h0);

    // Reset while a write waits for Mem_Ack
`ifdef DATA_MEM_BYTE_ENABLE_EN
    req(1'b1, 1'b0, 32'h0000_0302, 32'h0000_0077);
    tick(); Mem_Req = 1'b0;
`else
    req(1'b1, 1'b1, 32'h0000_0302, 32'h0000_0077);
    Mem_Ack = 1'b1; Mem_RData = 32'h9988_7766;
    tick(); Mem_Req = 1'b0;
    tick(); Mem_Ack = 1'b0;
`endif
    chk("rw_wr",    32'(Mem_Wr), 32'h1);
    tick();
    chk("rw_wait",  32'(Mem_Wr), 32'h1);
    chk("rw_ndone", 32'(Done),   32'h0);
    rst_n = 1'b0;
    tick();
    chk("rw_wroff", 32'(Mem_Wr), 32'h0);
    chk("rw_busy",  32'(Busy),   32'h0);
    chk("rw_done",  32'(Done),   32'h0);
    chk("rw_load",  Load_Memory, 32'h0);
    rst_n = 1'b1; Mem_Ack = 1'b1;
    tick();
    chk("rw_nodone", 32'(Done),   32'h0);
    chk("rw_nowr",   32'(Mem_Wr), 32'h0);
    Mem_Ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/data_mem_interface.md
# data_mem_interface

Multi-cycle access controller between the core's memory stage and the word-organised data memory. It latches a load/store request, runs a strobe/acknowledge handshake with the memory, and performs byte stores as read-modify-write on word-only memory. For loads it presents the registered memory word plus byte offset to the downstream load-alignment stage, which selects the word or the zero-extended byte.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- Mem_Req  in  1  start access; sampled only in IDLE
- Mem_Write  in  1  1 = store, 0 = load; latched with Mem_Req
- Store_Select  in  1  1 = byte store, 0 = word store; ignored for loads
- Address  in  32  byte address; latched with Mem_Req
- Store_Data  in  32  store data; byte stores use [7:0]
- Busy  out  1  high from cycle after acceptance through DONE
- Done  out  1  one-cycle pulse at completion
- Load_Memory  out  32  registered word read by last load; holds until next load completes
- Offset  out  2  registered Address[1:0] of last accepted access
- Mem_Addr  out  30  word address, Address[31:2]
- Mem_Rd  out  1  read strobe
- Mem_Wr  out  1  write strobe
- Mem_WData  out  32  write data
- Mem_BE  out  4  byte enables
- Mem_Ack  in  1  memory acknowledge; may be high in first strobe cycle
- Mem_RData  in  32  read data, valid when Mem_Ack=1 with Mem_Rd=1

## Operation
- States: IDLE, RD, RMW_RD, RMW_WR, WR, DONE.
- IDLE, Mem_Req=1: latch Address, Store_Data, Mem_Write, Store_Select; next state:
  - load → RD
  - word store → WR
  - byte store → RMW_RD
- RD: Mem_Rd=1; on Mem_Ack capture Mem_RData into Load_Memory → DONE.
- RMW_RD: Mem_Rd=1; on Mem_Ack, merge data into the internal write buffer (not Load_Memory) → RMW_WR.
  - Merge: byte lane k = Offset replaced by Store_Data[7:0]; other lanes kept.
- WR / RMW_WR: Mem_Wr=1, Mem_WData = latched word or merged word; on Mem_Ack → DONE.
- DONE: Done=1 for one cycle → IDLE.
- Strobes and Mem_Addr/Mem_WData stay stable while waiting for Mem_Ack; wait is unbounded.
- Mem_Rd and Mem_Wr are never both high.
- Mem_Req outside IDLE is ignored, not queued; Mem_Req in DONE is also ignored.
- Mem_BE = 4'b1111 in all write states unless the configuration macro changes it; 4'b0000 when Mem_Wr=0.
- Misaligned word accesses: Address[1:0] is ignored for the memory address; Offset is still reported.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, Busy=0, Done=0, Mem_Rd=0, Mem_Wr=0, Load_Memory=0, Offset=0, Mem_Addr=0, Mem_WData=0, Mem_BE=0.
- Reset mid-transaction aborts it; strobes are low the cycle after the reset edge, and no Done is produced.
- Strobes are registered; first strobe cycle is the cycle after the Mem_Req acceptance edge.
- With Mem_Ack high in the first strobe cycle:
  - load / word store: Done 2 cycles after acceptance
  - byte store (RMW): Done 3 cycles after acceptance
- Each extra wait cycle adds 1 cycle to latency.
- Load_Memory and Offset are valid in the Done cycle and afterwards.
- Back-to-back: a new Mem_Req is accepted in the cycle after Done, i.e. the first IDLE cycle.

## Configuration
- Macro: DATA_MEM_BYTE_ENABLE_EN.
- Defined: byte stores go IDLE → WR directly, with:
  - Mem_BE = one-hot of Offset
  - Mem_WData = Store_Data[7:0] replicated to all four lanes
  - RMW states unreachable; byte-store latency equals word-store latency (2 cycles).
- Undefined: read-modify-write as described; Mem_BE = 4'b1111 on every write.

## Test plan
- Load, zero-wait: Address=0x0000_0104, Mem_RData=0xA1B2C3D4 → Mem_Addr=0x41, Load_Memory=0xA1B2C3D4, Offset=2'b00, Done 2 cycles after Mem_Req.
- Load, 3 wait cycles: Address=0x0000_0013 → Mem_Rd held 4 cycles with stable Mem_Addr=0x4, Offset=2'b11, Done 5 cycles after acceptance.
- Byte store RMW (macro off): memory word 0x11223344, Address offset 2'b01, Store_Data=0x000000EE → one read, then write Mem_WData=0x1122EE44 with Mem_BE=4'b1111, Done 3 cycles after acceptance, Load_Memory unchanged.
- Byte store (macro on): same stimulus → single write, Mem_WData=0xEEEEEEEE, Mem_BE=4'b0010, Done 2 cycles after acceptance.
- Mem_Req pulsed while Busy=1 → ignored; exactly one Done; no extra strobe.
- rst_n=0 during RMW_WR wait → next cycle Mem_Wr=0, Busy=0, Done never asserted, Load_Memory=0.
